// File: rtl/adc_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adc_scan_ctrl_pkg
// Description : Shared types and constants for the ADC scan sequencer:
//               FSM state encoding, channel indices, default timing values
//               and the round-robin channel step helper.
// Revision    : 1.0 - initial release
// ============================================================================
package adc_scan_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_START  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_RD_HI  = 3'd4,
        ST_RD_LO  = 3'd5,
        ST_STORE  = 3'd6
    } state_t;

    localparam logic [1:0] CH_TEMP = 2'd0;
    localparam logic [1:0] CH_SETT = 2'd1;
    localparam logic [1:0] CH_TIME = 2'd2;

    localparam int DEF_SETTLE  = 15;
    localparam int DEF_TIMEOUT = 255;
    localparam int DEF_RD_HOLD = 2;

    // Round-robin step 0->1->2->0; the unused code 3 also maps back to 0.
    function automatic logic [1:0] next_ch(input logic [1:0] ch);
        logic [1:0] nxt;
        case (ch)
            CH_TEMP: nxt = CH_SETT;
            CH_SETT: nxt = CH_TIME;
            default: nxt = CH_TEMP;
        endcase
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adc_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : adc_scan_ctrl_if
// Description : Bundle of the scan controller's ADC bus, scan control and
//               holding-register outputs. master = controller side,
//               slave = ADC / system side.
// Revision    : 1.0 - initial release
// ============================================================================
interface adc_scan_ctrl_if;
    logic       enable;
    logic       adc_int;
    logic [3:0] adc_data;
    logic       adc_start;
    logic       adc_rd;
    logic       nibble_sel;
    logic [1:0] ch_sel;
    logic [7:0] current_temp;
    logic [7:0] set_temp;
    logic [3:0] set_time;
    logic       sample_valid;
    logic       scan_done;
    logic       timeout_err;

    modport master (
        input  enable, adc_int, adc_data,
        output adc_start, adc_rd, nibble_sel, ch_sel,
               current_temp, set_temp, set_time,
               sample_valid, scan_done, timeout_err
    );

    modport slave (
        output enable, adc_int, adc_data,
        input  adc_start, adc_rd, nibble_sel, ch_sel,
               current_temp, set_temp, set_time,
               sample_valid, scan_done, timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/adc_scan_ctrl_sync2.sv
`default_nettype none
// ============================================================================
// Module      : adc_scan_ctrl_sync2
// Description : Two-flop synchronizer with asynchronous active-low reset.
//               Reset value is selectable so active-low inputs reset to
//               their inactive level.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_scan_ctrl_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic d,
    output logic      q
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/adc_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : adc_scan_ctrl
// Description : Round-robin scan sequencer for a shared 4-bit-bus ADC.
//               Per channel: select mux, settle, start conversion, wait for
//               end-of-conversion, read two nibbles, update holding register.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_scan_ctrl
    import adc_scan_ctrl_pkg::*;
#(
    parameter int SETTLE  = DEF_SETTLE,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int RD_HOLD = DEF_RD_HOLD
) (
    input  wire logic         clk,
    input  wire logic         rst,
    adc_scan_ctrl_if.master   bus
);

    localparam int CNT_MAX = (SETTLE > TIMEOUT) ?
                             ((SETTLE  > RD_HOLD) ? SETTLE  : RD_HOLD) :
                             ((TIMEOUT > RD_HOLD) ? TIMEOUT : RD_HOLD);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RD_LAST      = CNT_W'(RD_HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             w_int_sync;
    logic             w_eoc;
    logic             w_timeout;
    logic             w_advance;
    logic             w_store_edge;
    logic             w_hi_capture;

    logic             r_adc_start;
    logic             r_adc_rd;
    logic             r_nibble_sel;
    logic             r_sample_valid;
    logic             r_scan_done;
    logic             r_timeout_err;
    logic             r_enable_q;
    logic [1:0]       r_ch_sel;
    logic [3:0]       r_sample_hi;
    logic [7:0]       r_current_temp;
    logic [7:0]       r_set_temp;
    logic [3:0]       r_set_time;

    adc_scan_ctrl_sync2 #(
        .RESET_VAL (1'b1)
    ) u_sync_int (
        .clk (clk),
        .rst (rst),
        .d   (bus.adc_int),
        .q   (w_int_sync)
    );

    assign w_eoc = ~w_int_sync;

    // Abandon a conversion once the wait budget is spent without eoc.
    assign w_timeout    = (r_state == ST_WAIT) && bus.enable && !w_eoc &&
                          (r_cnt == TIMEOUT_LAST);
    assign w_advance    = w_timeout || (r_state == ST_STORE);
    assign w_store_edge = (r_state == ST_RD_LO) && (w_next == ST_STORE);
    assign w_hi_capture = (r_state == ST_RD_HI) && (r_cnt == RD_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; dropping enable aborts any in-flight step.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.enable) w_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (!bus.enable)              w_next = ST_IDLE;
                else if (r_cnt == SETTLE_LAST) w_next = ST_START;
            end
            ST_START: begin
                if (!bus.enable) w_next = ST_IDLE;
                else             w_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (!bus.enable)                 w_next = ST_IDLE;
                else if (w_eoc)                  w_next = ST_RD_HI;
                else if (r_cnt == TIMEOUT_LAST)  w_next = ST_SETTLE;
            end
            ST_RD_HI: begin
                if (!bus.enable)          w_next = ST_IDLE;
                else if (r_cnt == RD_LAST) w_next = ST_RD_LO;
            end
            ST_RD_LO: begin
                if (!bus.enable)          w_next = ST_IDLE;
                else if (r_cnt == RD_LAST) w_next = ST_STORE;
            end
            ST_STORE: begin
                w_next = bus.enable ? ST_SETTLE : ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Shared step counter: restarts on every state change, idle holds zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if ((w_next != r_state) || (r_state == ST_IDLE)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_ONE;
        end
    end

    // Strobes registered from the next state so they track the state flops glitch-free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_adc_start    <= 1'b0;
            r_adc_rd       <= 1'b0;
            r_nibble_sel   <= 1'b0;
            r_sample_valid <= 1'b0;
            r_scan_done    <= 1'b0;
        end else begin
            r_adc_start    <= (w_next == ST_START);
            r_adc_rd       <= (w_next == ST_RD_HI) || (w_next == ST_RD_LO);
            r_nibble_sel   <= (w_next == ST_RD_HI);
            r_sample_valid <= (w_next == ST_STORE);
            r_scan_done    <= ((w_next == ST_STORE) || w_timeout) &&
                              (r_ch_sel == CH_TIME);
        end
    end

    // Sample capture, holding registers (visible from the STORE cycle on), channel step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sample_hi    <= 4'h0;
            r_current_temp <= 8'h00;
            r_set_temp     <= 8'h00;
            r_set_time     <= 4'h0;
            r_ch_sel       <= CH_TEMP;
        end else begin
            if (w_hi_capture) begin
                r_sample_hi <= bus.adc_data;
            end
            if (w_store_edge) begin
                case (r_ch_sel)
                    CH_TEMP: r_current_temp <= {r_sample_hi, bus.adc_data};
                    CH_SETT: r_set_temp     <= {r_sample_hi, bus.adc_data};
                    CH_TIME: r_set_time     <= r_sample_hi;
                    default: ;
                endcase
            end
            if (w_advance) begin
                r_ch_sel <= next_ch(r_ch_sel);
            end else if (r_ch_sel == 2'd3) begin
                r_ch_sel <= CH_TEMP;
            end
        end
    end

    // Sticky timeout flag, cleared on a rising edge of enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_enable_q    <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_enable_q <= bus.enable;
            if (bus.enable && !r_enable_q) begin
                r_timeout_err <= 1'b0;
            end else if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign bus.adc_start    = r_adc_start;
    assign bus.adc_rd       = r_adc_rd;
    assign bus.nibble_sel   = r_nibble_sel;
    assign bus.ch_sel       = r_ch_sel;
    assign bus.current_temp = r_current_temp;
    assign bus.set_temp     = r_set_temp;
    assign bus.set_time     = r_set_time;
    assign bus.sample_valid = r_sample_valid;
    assign bus.scan_done    = r_scan_done;
    assign bus.timeout_err  = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_adc_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_scan_ctrl
// Description : Directed self-checking bench for adc_scan_ctrl with a simple
//               behavioural ADC (programmable eoc delay, per-channel data).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_scan_ctrl;
    import adc_scan_ctrl_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    adc_scan_ctrl_if bus ();

    adc_scan_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ADC model state
    logic [7:0] adc_val [4];
    bit         no_eoc  [4];
    int         eoc_delay;
    logic       model_int;
    logic       glitch_n;
    bit         pend;
    int         pend_cnt;

    assign bus.adc_int  = model_int & glitch_n;
    assign bus.adc_data = bus.nibble_sel ? adc_val[bus.ch_sel][7:4]
                                         : adc_val[bus.ch_sel][3:0];

    // ADC: pull INT low eoc_delay cycles after a start, release it on a read.
    initial begin
        model_int = 1'b1;
        pend      = 1'b0;
        pend_cnt  = 0;
        forever begin
            @(posedge clk);
            #2;
            if (!rst) begin
                pend      = 1'b0;
                model_int = 1'b1;
            end else begin
                if (bus.adc_rd) model_int = 1'b1;
                if (bus.adc_start) begin
                    pend     = !no_eoc[bus.ch_sel];
                    pend_cnt = eoc_delay;
                end else if (pend) begin
                    pend_cnt = pend_cnt - 1;
                    if (pend_cnt == 0) begin
                        model_int = 1'b0;
                        pend      = 1'b0;
                    end
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst        = 1'b0;
        bus.enable = 1'b0;
        glitch_n   = 1'b1;
        eoc_delay  = 10;
        for (int i = 0; i < 4; i++) begin
            no_eoc[i]  = 1'b0;
            adc_val[i] = 8'h00;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Edges until condition holds (sampled 1 ns after each edge); -1 if budget expires.
    task automatic wait_until(input int sel, input int budget, output int cycles);
        bit hit;
        cycles = -1;
        hit    = 1'b0;
        for (int i = 1; i <= budget && !hit; i++) begin
            @(posedge clk);
            #1;
            case (sel)
                0: hit = bus.adc_start;
                1: hit = bus.sample_valid;
                2: hit = bus.scan_done;
                3: hit = bus.timeout_err;
                4: hit = bus.adc_rd && !bus.nibble_sel;
                default: hit = 1'b0;
            endcase
            if (hit) cycles = i;
        end
    endtask

    task automatic test_reset();
        rst        = 1'b0;
        bus.enable = 1'b0;
        glitch_n   = 1'b1;
        eoc_delay  = 10;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.ch_sel !== 2'd0 || bus.current_temp !== 8'h00 ||
            bus.set_temp !== 8'h00 || bus.set_time !== 4'h0) begin
            errors++;
            $display("FAIL reset_data ch_sel=%0d temp=%h sett=%h time=%h required 0/00/00/0",
                     bus.ch_sel, bus.current_temp, bus.set_temp, bus.set_time);
        end
        checks++;
        if ({bus.adc_start, bus.adc_rd, bus.nibble_sel, bus.sample_valid,
             bus.scan_done, bus.timeout_err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_strobes got %b required 000000",
                     {bus.adc_start, bus.adc_rd, bus.nibble_sel, bus.sample_valid,
                      bus.scan_done, bus.timeout_err});
        end
    endtask

    task automatic test_first_channel();
        int c;
        do_reset();
        adc_val[0] = 8'h5A;
        bus.enable = 1'b1;
        wait_until(0, 40, c);
        checks++;
        if (c != 16) begin
            errors++;
            $display("FAIL first_start_latency got %0d required 16", c);
        end
        wait_until(1, 60, c);
        checks++;
        if (c != 17) begin
            errors++;
            $display("FAIL first_store_latency got %0d required 17", c);
        end
        checks++;
        if (bus.current_temp !== 8'h5A) begin
            errors++;
            $display("FAIL first_temp got %h required 5a", bus.current_temp);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.sample_valid !== 1'b0 || bus.ch_sel !== 2'd1) begin
            errors++;
            $display("FAIL first_step sample_valid=%b ch_sel=%0d required 0/1",
                     bus.sample_valid, bus.ch_sel);
        end
        bus.enable = 1'b0;
    endtask

    task automatic test_full_scan();
        int  nsv;
        int  nsd;
        do_reset();
        adc_val[0] = 8'h96;
        adc_val[1] = 8'hC8;
        adc_val[2] = 8'h73;
        bus.enable = 1'b1;
        nsv = 0;
        nsd = 0;
        for (int i = 0; i < 200 && nsd == 0; i++) begin
            @(posedge clk);
            #1;
            if (bus.sample_valid) nsv++;
            if (bus.scan_done)    nsd++;
        end
        checks++;
        if (nsd != 1 || nsv != 3) begin
            errors++;
            $display("FAIL scan_pulses scan_done=%0d sample_valid=%0d required 1/3", nsd, nsv);
        end
        checks++;
        if (bus.current_temp !== 8'h96 || bus.set_temp !== 8'hC8 || bus.set_time !== 4'h7) begin
            errors++;
            $display("FAIL scan_values got %h/%h/%h required 96/c8/7",
                     bus.current_temp, bus.set_temp, bus.set_time);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.ch_sel !== 2'd0 || bus.scan_done !== 1'b0) begin
            errors++;
            $display("FAIL scan_wrap ch_sel=%0d scan_done=%b required 0/0",
                     bus.ch_sel, bus.scan_done);
        end
        bus.enable = 1'b0;
    endtask

    task automatic test_timeout();
        int c;
        do_reset();
        adc_val[0] = 8'h11;
        adc_val[2] = 8'h2B;
        no_eoc[1]  = 1'b1;
        bus.enable = 1'b1;
        wait_until(1, 60, c);
        wait_until(0, 40, c);
        checks++;
        if (c < 0 || bus.ch_sel !== 2'd1) begin
            errors++;
            $display("FAIL to_ch1_start cycles=%0d ch_sel=%0d required start on ch 1", c, bus.ch_sel);
        end
        wait_until(3, 300, c);
        checks++;
        if (c != 256) begin
            errors++;
            $display("FAIL to_latency got %0d required 256", c);
        end
        checks++;
        if (bus.ch_sel !== 2'd2 || bus.set_temp !== 8'h00 || bus.sample_valid !== 1'b0) begin
            errors++;
            $display("FAIL to_skip ch_sel=%0d set_temp=%h sample_valid=%b required 2/00/0",
                     bus.ch_sel, bus.set_temp, bus.sample_valid);
        end
        wait_until(2, 80, c);
        checks++;
        if (c < 0 || bus.set_time !== 4'h2 || bus.timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL to_ch2 cycles=%0d set_time=%h timeout_err=%b required 2/1",
                     c, bus.set_time, bus.timeout_err);
        end
        bus.enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL to_sticky got %b required 1", bus.timeout_err);
        end
        bus.enable = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL to_clear got %b required 0", bus.timeout_err);
        end
        bus.enable = 1'b0;
    endtask

    task automatic test_enable_drop();
        int c;
        do_reset();
        adc_val[0] = 8'h3C;
        adc_val[1] = 8'h44;
        adc_val[2] = 8'h55;
        bus.enable = 1'b1;
        wait_until(2, 200, c);
        adc_val[0] = 8'hE1;
        wait_until(4, 80, c);
        checks++;
        if (c < 0 || bus.ch_sel !== 2'd0) begin
            errors++;
            $display("FAIL drop_reach_rdlo cycles=%0d ch_sel=%0d required RD_LO on ch 0", c, bus.ch_sel);
        end
        bus.enable = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.adc_rd !== 1'b0 || bus.current_temp !== 8'h3C ||
            bus.sample_valid !== 1'b0 || bus.ch_sel !== 2'd0) begin
            errors++;
            $display("FAIL drop_abort rd=%b temp=%h sv=%b ch_sel=%0d required 0/3c/0/0",
                     bus.adc_rd, bus.current_temp, bus.sample_valid, bus.ch_sel);
        end
        repeat (3) @(posedge clk);
        #1;
        bus.enable = 1'b1;
        wait_until(0, 40, c);
        checks++;
        if (c != 16 || bus.ch_sel !== 2'd0) begin
            errors++;
            $display("FAIL drop_resume cycles=%0d ch_sel=%0d required 16/0", c, bus.ch_sel);
        end
        wait_until(1, 60, c);
        checks++;
        if (c != 17 || bus.current_temp !== 8'hE1) begin
            errors++;
            $display("FAIL drop_rescan cycles=%0d temp=%h required 17/e1", c, bus.current_temp);
        end
        bus.enable = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        int c;
        do_reset();
        adc_val[0] = 8'h5A;
        bus.enable = 1'b1;
        wait_until(1, 60, c);
        wait_until(0, 40, c);
        repeat (3) @(posedge clk);
        #4;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.ch_sel !== 2'd0 || bus.current_temp !== 8'h00 ||
            bus.adc_start !== 1'b0 || bus.adc_rd !== 1'b0) begin
            errors++;
            $display("FAIL async_reset ch_sel=%0d temp=%h start=%b rd=%b required 0/00/0/0",
                     bus.ch_sel, bus.current_temp, bus.adc_start, bus.adc_rd);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        wait_until(0, 40, c);
        checks++;
        if (c != 16 || bus.ch_sel !== 2'd0) begin
            errors++;
            $display("FAIL reset_restart cycles=%0d ch_sel=%0d required 16/0", c, bus.ch_sel);
        end
        wait_until(1, 60, c);
        checks++;
        if (bus.current_temp !== 8'h5A) begin
            errors++;
            $display("FAIL reset_rescan temp=%h required 5a", bus.current_temp);
        end
        bus.enable = 1'b0;
    endtask

    task automatic test_glitch();
        int c;
        int nrd;
        int total;
        do_reset();
        adc_val[0] = 8'h77;
        bus.enable = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        glitch_n = 1'b0;
        @(posedge clk);
        #1;
        glitch_n = 1'b1;
        total = 5;
        nrd   = 0;
        c     = 0;
        for (int i = 0; i < 40 && c == 0; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (bus.adc_rd) nrd++;
            if (bus.adc_start) c = 1;
        end
        checks++;
        if (nrd != 0 || total != 16) begin
            errors++;
            $display("FAIL glitch_ignored rd_cycles=%0d start_at=%0d required 0/16", nrd, total);
        end
        wait_until(1, 60, c);
        checks++;
        if (c != 17 || bus.current_temp !== 8'h77) begin
            errors++;
            $display("FAIL glitch_conv cycles=%0d temp=%h required 17/77", c, bus.current_temp);
        end
        bus.enable = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 4; i++) begin
            no_eoc[i]  = 1'b0;
            adc_val[i] = 8'h00;
        end
        test_reset();
        test_first_channel();
        test_full_scan();
        test_timeout();
        test_enable_drop();
        test_reset_mid_wait();
        test_glitch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
